// File: rtl/axi4_default_slave.sv
// Default AXI4 responder: completes every unmapped AW/AR transaction with DECERR; W data ignored, R data zero.
// B/first R beat one cycle after the last W / AR handshake; B and R outputs hold stable under bready/rready backpressure.
module axi4_default_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t   w_state, w_next;
  r_state_t   r_state, r_next;
  logic [7:0] beat_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;

  assign bresp = 2'b11;
  assign rresp = 2'b11;
  assign rdata = '0;

  // Write FSM
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)         w_next = W_DATA;
      W_DATA:  if (w_hs && wlast) w_next = W_RESP;
      W_RESP:  if (b_hs)          w_next = W_IDLE;
      default:                    w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst)        bid <= '0;
    else if (aw_hs) bid <= awid;
  end

  // Read FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)         r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default:                    r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = (r_state == R_DATA) && (beat_cnt == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rid      <= '0;
      beat_cnt <= 8'd0;
    end else if (ar_hs) begin
      rid      <= arid;
      beat_cnt <= arlen;
    end else if (r_hs && beat_cnt != 8'd0) begin
      beat_cnt <= beat_cnt - 8'd1;
    end
  end

  // Debug: a simultaneous AW+AR counts twice; the sum is clamped at all-ones
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'd0;
      err_addr  <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (aw_hs)      err_addr <= awaddr;
      else if (ar_hs) err_addr <= araddr;
    end
  end

endmodule

// File: tb/tb_axi4_default_slave.sv
// Bench for axi4_default_slave: scenario tasks with randomized bursts against a transaction-level model.
module tb_axi4_default_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [31:0] exp_addr = '0;
  int raw_reqs = 0;

  axi4_default_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Request tally: every address handshake seen on the bus is one unmapped request
  always @(posedge clk) begin
    if (rst) raw_reqs = 0;
    else raw_reqs = raw_reqs + int'(awvalid && awready) + int'(arvalid && arready);
  end

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    exp_cnt = 0;
    exp_addr = '0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input int stall);
    int t;
    int s;
    logic last_exp;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    while (arready !== 1'b1 && t < 20) begin tick; t++; end
    checks++;
    if (t == 20) begin failures++; $display("FAIL rd_ar_timeout arready=%b required=1", arready); end
    tick;
    arvalid = 1'b0;
    exp_cnt = sat16(exp_cnt + 1);
    exp_addr = addr;
    for (int b = 0; b <= int'(len); b++) begin
      last_exp = (b == int'(len));
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int k = 0; k < s; k++) begin
        checks++;
        if ({rvalid, rid, rlast} !== {1'b1, id, last_exp}) begin
          failures++;
          $display("FAIL rd_hold beat=%0d got v/id/last=%b/%0d/%b required 1/%0d/%b", b, rvalid, rid, rlast, id, last_exp);
        end
        tick;
      end
      rready = 1'b1;
      checks++;
      if ({rvalid, rid, rlast, rresp, rdata} !== {1'b1, id, last_exp, 2'b11, 32'd0}) begin
        failures++;
        $display("FAIL rd_beat beat=%0d got v/id/last/resp/data=%b/%0d/%b/%b/%h required 1/%0d/%b/11/0",
                 b, rvalid, rid, rlast, rresp, rdata, id, last_exp);
      end
      tick;
      rready = 1'b0;
    end
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_end got rvalid/arready=%b/%b required 0/1", rvalid, arready);
    end
    checks++;
    if (err_count !== 16'(exp_cnt) || err_addr !== exp_addr) begin
      failures++;
      $display("FAIL rd_debug got cnt/addr=%0d/%h required %0d/%h", err_count, err_addr, exp_cnt, exp_addr);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int beats, input int bdelay);
    int t;
    awid = id; awaddr = addr; awvalid = 1'b1; bready = 1'b0;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin tick; t++; end
    checks++;
    if (t == 20) begin failures++; $display("FAIL wr_aw_timeout awready=%b required=1", awready); end
    tick;
    awvalid = 1'b0;
    exp_cnt = sat16(exp_cnt + 1);
    exp_addr = addr;
    checks++;
    if ({wready, awready} !== 2'b10) begin
      failures++;
      $display("FAIL wr_wready got wready/awready=%b/%b required 1/0", wready, awready);
    end
    for (int b = 0; b < beats; b++) begin
      wvalid = 1'b0;
      if ($urandom_range(0, 1) == 1) tick;
      wvalid = 1'b1;
      wlast = (b == beats - 1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({bvalid, bid, bresp, wready} !== {1'b1, id, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL wr_b got v/id/resp/wready=%b/%0d/%b/%b required 1/%0d/11/0", bvalid, bid, bresp, wready, id);
    end
    for (int k = 0; k < bdelay; k++) begin
      tick;
      checks++;
      if ({bvalid, bid} !== {1'b1, id}) begin
        failures++;
        $display("FAIL wr_b_hold cyc=%0d got v/id=%b/%0d required 1/%0d", k, bvalid, bid, id);
      end
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    checks++;
    if ({bvalid, awready} !== 2'b01) begin
      failures++;
      $display("FAIL wr_end got bvalid/awready=%b/%b required 0/1", bvalid, awready);
    end
    checks++;
    if (err_count !== 16'(exp_cnt) || err_addr !== exp_addr) begin
      failures++;
      $display("FAIL wr_debug got cnt/addr=%0d/%h required %0d/%h", err_count, err_addr, exp_cnt, exp_addr);
    end
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl got aw/ar/w/b/r/last=%b required 110000",
               {awready, arready, wready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bid, rid, err_count, err_addr} !== 56'd0) begin
      failures++;
      $display("FAIL reset_regs got bid/rid/cnt/addr=%0d/%0d/%0d/%h required 0", bid, rid, err_count, err_addr);
    end
  endtask

  task automatic test_single_write;
    do_write(4'd3, 32'h0000_5000, 1, 0);
    checks++;
    if (err_count !== 16'd1 || err_addr !== 32'h0000_5000) begin
      failures++;
      $display("FAIL single_write_dbg got cnt/addr=%0d/%h required 1/00005000", err_count, err_addr);
    end
  endtask

  task automatic test_read_burst;
    do_read(4'd5, 32'hC000_4000, 8'd3, 0);
  endtask

  task automatic test_backpressure;
    do_read(4'd9, 32'h0001_0000, 8'd1, 3);
    do_write(4'd12, 32'h0002_0000, 4, 5);
  endtask

  task automatic test_concurrent;
    int rb, bb;
    logic [7:0] len;
    len = 8'($urandom_range(0, 5));
    awid = 4'd6; awaddr = 32'h1000_0000; arid = 4'd7; araddr = 32'h2000_0000; arlen = len;
    awvalid = 1'b1; arvalid = 1'b1;
    checks++;
    if ({awready, arready} !== 2'b11) begin
      failures++;
      $display("FAIL conc_idle got awready/arready=%b/%b required 1/1", awready, arready);
    end
    tick;
    awvalid = 1'b0; arvalid = 1'b0;
    exp_cnt = sat16(exp_cnt + 2);
    exp_addr = 32'h1000_0000;
    checks++;
    if (err_count !== 16'(exp_cnt) || err_addr !== exp_addr) begin
      failures++;
      $display("FAIL conc_debug got cnt/addr=%0d/%h required %0d/10000000", err_count, err_addr, exp_cnt);
    end
    wvalid = 1'b1; wlast = 1'b1; bready = 1'b1; rready = 1'b1;
    rb = 0; bb = 0;
    for (int c = 0; c < 20; c++) begin
      if (rvalid && rready) rb++;
      if (bvalid && bready) bb++;
      if (wvalid && wready) begin tick; wvalid = 1'b0; wlast = 1'b0; end
      else tick;
    end
    bready = 1'b0; rready = 1'b0;
    checks++;
    if (rb !== int'(len) + 1 || bb !== 1) begin
      failures++;
      $display("FAIL conc_complete got rbeats/bresps=%0d/%0d required %0d/1", rb, bb, int'(len) + 1);
    end
    checks++;
    if ({rvalid, bvalid, awready, arready} !== 4'b0011) begin
      failures++;
      $display("FAIL conc_idle_after got r/b/aw/ar=%b required 0011", {rvalid, bvalid, awready, arready});
    end
  endtask

  task automatic test_reset_mid_burst;
    arid = 4'd2; araddr = 32'h0000_8000; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
    tick;
    arvalid = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; rready = 1'b0;
    exp_cnt = 0; exp_addr = '0;
    checks++;
    if ({rvalid, rlast, arready} !== 3'b001 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid got rvalid/rlast/arready/cnt=%b/%b/%b/%0d required 0/0/1/0", rvalid, rlast, arready, err_count);
    end
    do_read(4'd4, 32'h0000_9000, 8'd0, 0);
  endtask

  task automatic test_w_before_aw;
    wvalid = 1'b1; wlast = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (wready !== 1'b0) begin
        failures++;
        $display("FAIL w_early cyc=%0d got wready=%b required 0", c, wready);
      end
      tick;
    end
    awid = 4'd1; awaddr = 32'h0000_A000; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    exp_cnt = sat16(exp_cnt + 1);
    checks++;
    if (wready !== 1'b1) begin failures++; $display("FAIL w_after_aw got wready=%b required 1", wready); end
    tick;
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({bvalid, bid} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL w_early_b got bvalid/bid=%b/%0d required 1/1", bvalid, bid);
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) begin
      addr = $urandom | 32'h0000_4000;
      if ($urandom_range(0, 1) == 1)
        do_read(4'($urandom), addr, 8'($urandom_range(0, 20)), -1);
      else
        do_write(4'($urandom), addr, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    end
    do_read(4'hF, 32'hFFFF_FFFC, 8'd255, 0);
  endtask

  task automatic test_saturation;
    int c;
    logic near_done;
    apply_reset;
    awid = 4'd0; awaddr = 32'h0000_4000; araddr = 32'h0000_4004; arlen = 8'd0;
    awvalid = 1'b1; wvalid = 1'b1; wlast = 1'b1; bready = 1'b1; arvalid = 1'b1; rready = 1'b1;
    c = 0; near_done = 1'b0;
    while (raw_reqs < 65540 && c < 90000) begin
      tick; c++;
      if (!near_done && raw_reqs >= 65000) begin
        near_done = 1'b1;
        checks++;
        if (err_count !== 16'(raw_reqs)) begin
          failures++;
          $display("FAIL sat_pre got cnt=%0d required %0d", err_count, raw_reqs);
        end
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    tick; tick; tick;
    bready = 1'b0; rready = 1'b0;
    checks++;
    if (raw_reqs < 65540) begin failures++; $display("FAIL sat_timeout got reqs=%0d required >=65540", raw_reqs); end
    checks++;
    if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got cnt=%h required ffff", err_count); end
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awvalid = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset;
    test_single_write;
    test_read_burst;
    test_backpressure;
    test_concurrent;
    test_reset_mid_burst;
    test_w_before_aw;
    test_random;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
